// File: rtl/dram_cmd_timer.sv
// Command timing stage between the controller FSM and the DRAM command bus.
// Holds each request until per-bank tRCD/tRAS/tRP and global tRFC are met.
module dram_cmd_timer #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int T_RCD           = 6,
  parameter int T_RAS           = 16,
  parameter int T_RP            = 6,
  parameter int T_RFC           = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_req,
  input  logic [1:0]                         cmd,
  input  logic                               we,
  input  logic [$clog2(NUMBER_OF_BANKS)-1:0] bank_id,
  input  logic [$clog2(NUMBER_OF_ROWS)-1:0]  row_id,
  input  logic [$clog2(NUMBER_OF_COLS)-1:0]  col_id,
  output logic                               cmd_ack,
  output logic                               cmd_err,
  output logic                               dram_cmd_valid,
  output logic [1:0]                         dram_cmd,
  output logic                               dram_we,
  output logic [$clog2(NUMBER_OF_BANKS)-1:0] dram_bank,
  output logic [$clog2(NUMBER_OF_ROWS)-1:0]  dram_row,
  output logic [$clog2(NUMBER_OF_COLS)-1:0]  dram_col,
  output logic [NUMBER_OF_BANKS-1:0]         bank_open
);

  localparam int BANK_W  = $clog2(NUMBER_OF_BANKS);
  localparam int ROW_W   = $clog2(NUMBER_OF_ROWS);
  localparam int COL_W   = $clog2(NUMBER_OF_COLS);
  localparam int CNT_MAX = (T_RAS > T_RFC) ? T_RAS : T_RFC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

  localparam logic [1:0] CMD_REF = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_COL = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_ACK} state_t;
  state_t state;

  logic [1:0]       cmd_p0;
  logic             we_p0;
  logic [BANK_W-1:0] bank_p0;
  logic [ROW_W-1:0] row_p0;
  logic [COL_W-1:0] col_p0;

  logic [CNT_W-1:0] cnt_act [NUMBER_OF_BANKS];
  logic [CNT_W-1:0] cnt_pre [NUMBER_OF_BANKS];
  logic [CNT_W-1:0] cnt_ref;
  logic [ROW_W-1:0] open_row [NUMBER_OF_BANKS];

  logic all_pre_ok, legal, noop, ready, issue;

  // Decision is made the cycle before the strobe, hence the +1 look-ahead.
  function automatic logic met(input logic [CNT_W-1:0] cnt, input int t);
    return (int'(cnt) + 1) >= t;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_SAT) ? CNT_SAT : c + 1'b1;
  endfunction

  always_comb begin
    all_pre_ok = 1'b1;
    for (int b = 0; b < NUMBER_OF_BANKS; b++)
      if (!met(cnt_pre[b], T_RP)) all_pre_ok = 1'b0;
    legal = 1'b1;
    noop  = 1'b0;
    ready = 1'b0;
    case (cmd_p0)
      CMD_REF: begin legal = ~|bank_open;        ready = all_pre_ok;                  end
      CMD_ACT: begin legal = !bank_open[bank_p0]; ready = met(cnt_pre[bank_p0], T_RP);  end
      CMD_COL: begin legal = bank_open[bank_p0];  ready = met(cnt_act[bank_p0], T_RCD); end
      default: begin noop  = !bank_open[bank_p0]; ready = met(cnt_act[bank_p0], T_RAS); end
    endcase
    ready = ready && met(cnt_ref, T_RFC);
    issue = (state == S_WAIT) && legal && !noop && ready;
  end

  // Request fields are captured once, on acceptance
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cmd_req) begin
      cmd_p0  <= cmd;
      we_p0   <= we;
      bank_p0 <= bank_id;
      row_p0  <= row_id;
      col_p0  <= col_id;
    end
    if (issue && cmd_p0 == CMD_ACT) open_row[bank_p0] <= row_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cmd_ack        <= 1'b0;
      cmd_err        <= 1'b0;
      dram_cmd_valid <= 1'b0;
      dram_cmd       <= '0;
      dram_we        <= 1'b0;
      dram_bank      <= '0;
      dram_row       <= '0;
      dram_col       <= '0;
      bank_open      <= '0;
      cnt_ref        <= CNT_SAT;
      for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
        cnt_act[b] <= CNT_SAT;
        cnt_pre[b] <= CNT_SAT;
      end
    end else begin
      dram_cmd_valid <= 1'b0;
      cmd_err        <= 1'b0;
      cnt_ref        <= sat_inc(cnt_ref);
      for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
        cnt_act[b] <= sat_inc(cnt_act[b]);
        cnt_pre[b] <= sat_inc(cnt_pre[b]);
      end
      case (state)
        S_IDLE: if (cmd_req) state <= S_WAIT;
        S_WAIT: begin
          if (!legal) begin
            cmd_err <= 1'b1;
            cmd_ack <= 1'b1;
            state   <= S_ACK;
          end else if (noop) begin
            cmd_ack <= 1'b1;
            state   <= S_ACK;
          end else if (ready) begin
            dram_cmd_valid <= 1'b1;
            dram_cmd       <= cmd_p0;
            dram_we        <= we_p0;
            dram_bank      <= bank_p0;
            dram_col       <= col_p0;
            dram_row       <= (cmd_p0 == CMD_ACT) ? row_p0 :
                              (cmd_p0 == CMD_REF) ? '0 : open_row[bank_p0];
            state          <= S_ISSUE;
            case (cmd_p0)
              CMD_ACT: begin bank_open[bank_p0] <= 1'b1; cnt_act[bank_p0] <= '0; end
              CMD_PRE: begin bank_open[bank_p0] <= 1'b0; cnt_pre[bank_p0] <= '0; end
              CMD_REF: begin bank_open <= '0; cnt_ref <= '0; end
              default: ;
            endcase
          end
        end
        S_ISSUE: begin
          cmd_ack <= 1'b1;
          state   <= S_ACK;
        end
        default: if (!cmd_req) begin
          cmd_ack <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_timer.sv
// Directed bench for dram_cmd_timer: latency, per-bank timing distances,
// illegal-command errors, open-bank tracking and mid-operation reset.
module tb_dram_cmd_timer;

  localparam logic [1:0] REF = 2'b00, ACT = 2'b01, COL = 2'b10, PRE = 2'b11;

  logic       clk = 1'b0, rst = 1'b1, cmd_req = 1'b0, we = 1'b0;
  logic [1:0] cmd = '0;
  logic [2:0] bank_id = '0, col_id = '0;
  logic [6:0] row_id = '0;
  logic       cmd_ack, cmd_err, dram_cmd_valid, dram_we;
  logic [1:0] dram_cmd;
  logic [2:0] dram_bank, dram_col;
  logic [6:0] dram_row;
  logic [7:0] bank_open;

  dram_cmd_timer dut (
    .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd(cmd), .we(we),
    .bank_id(bank_id), .row_id(row_id), .col_id(col_id),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .dram_cmd_valid(dram_cmd_valid),
    .dram_cmd(dram_cmd), .dram_we(dram_we), .dram_bank(dram_bank),
    .dram_row(dram_row), .dram_col(dram_col), .bank_open(bank_open)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int req_cyc, v_cyc, e_cyc, ack_cyc, valid_cnt, err_cnt;
  logic [1:0] v_cmd;
  logic       v_we;
  logic [2:0] v_bank, v_col;
  logic [6:0] v_row;
  logic [7:0] v_open;

  // One four-phase transaction; inputs are scrambled after acceptance.
  task automatic send(input logic [1:0] c, input logic w, input logic [2:0] b,
                      input logic [6:0] r, input logic [2:0] col, input bit hold);
    @(negedge clk);
    cmd_req = 1'b1; cmd = c; we = w; bank_id = b; row_id = r; col_id = col;
    req_cyc = cyc + 1;
    valid_cnt = 0; err_cnt = 0; ack_cyc = -1; v_cyc = -1; e_cyc = -1;
    for (int i = 0; i < 100 && ack_cyc < 0; i++) begin
      @(negedge clk);
      cmd = ~c; we = ~w; bank_id = ~b; row_id = ~r; col_id = ~col;
      if (dram_cmd_valid) begin
        valid_cnt++; v_cyc = cyc; v_cmd = dram_cmd; v_we = dram_we;
        v_bank = dram_bank; v_row = dram_row; v_col = dram_col; v_open = bank_open;
      end
      if (cmd_err) begin err_cnt++; e_cyc = cyc; end
      if (cmd_ack) ack_cyc = cyc;
    end
    chk("ack_seen", 32'(ack_cyc >= 0), 1);
    if (hold) begin
      @(negedge clk);
      chk("ack_hold", cmd_ack, 1);
    end
    cmd_req = 1'b0;
    @(negedge clk);
    chk("ack_fall", cmd_ack, 0);
  endtask

  int act3_v, pre2_v, ref_v, quiet;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", cmd_ack, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_valid", dram_cmd_valid, 0);
    chk("rst_cmd", dram_cmd, 0);
    chk("rst_we", dram_we, 0);
    chk("rst_bank", dram_bank, 0);
    chk("rst_row", dram_row, 0);
    chk("rst_col", dram_col, 0);
    chk("rst_open", bank_open, 0);
    rst = 1'b0;

    send(ACT, 1'b0, 3'd3, 7'd42, 3'd0, 1'b1);
    act3_v = v_cyc;
    chk("act_latency", v_cyc - req_cyc, 1);
    chk("act_ack_latency", ack_cyc - req_cyc, 2);
    chk("act_strobes", valid_cnt, 1);
    chk("act_cmd", v_cmd, 1);
    chk("act_bank", v_bank, 3);
    chk("act_row", v_row, 42);
    chk("act_open", v_open, 8'h08);

    send(COL, 1'b1, 3'd3, 7'd0, 3'd5, 1'b1);
    chk("col_trcd", v_cyc - act3_v, 6);
    chk("col_cmd", v_cmd, 2);
    chk("col_we", v_we, 1);
    chk("col_col", v_col, 5);
    chk("col_open", v_open, 8'h08);

    send(PRE, 1'b0, 3'd3, 7'd0, 3'd0, 1'b1);
    chk("pre_tras", v_cyc - act3_v, 16);
    chk("pre_cmd", v_cmd, 3);
    chk("pre_open", v_open, 8'h00);

    send(COL, 1'b0, 3'd1, 7'd0, 3'd2, 1'b0);
    chk("colx_err", err_cnt, 1);
    chk("colx_err_lat", e_cyc - req_cyc, 1);
    chk("colx_ack_lat", ack_cyc - req_cyc, 1);
    chk("colx_nostrobe", valid_cnt, 0);

    send(ACT, 1'b0, 3'd3, 7'd7, 3'd0, 1'b0);
    chk("act3b_open", v_open, 8'h08);
    send(ACT, 1'b0, 3'd3, 7'd9, 3'd0, 1'b0);
    chk("actx_err", err_cnt, 1);
    chk("actx_nostrobe", valid_cnt, 0);
    chk("actx_open", bank_open, 8'h08);

    send(PRE, 1'b0, 3'd3, 7'd0, 3'd0, 1'b0);
    send(ACT, 1'b0, 3'd0, 7'd1, 3'd0, 1'b0);
    send(ACT, 1'b0, 3'd2, 7'd2, 3'd0, 1'b0);
    chk("two_open", v_open, 8'h05);
    send(PRE, 1'b0, 3'd0, 7'd0, 3'd0, 1'b0);
    chk("pre0_open", v_open, 8'h04);
    send(PRE, 1'b0, 3'd2, 7'd0, 3'd0, 1'b0);
    pre2_v = v_cyc;
    send(REF, 1'b0, 3'd0, 7'd0, 3'd0, 1'b0);
    ref_v = v_cyc;
    chk("ref_trp", ref_v - pre2_v, 6);
    chk("ref_cmd", v_cmd, 0);
    chk("ref_open", v_open, 8'h00);
    send(ACT, 1'b0, 3'd0, 7'd11, 3'd0, 1'b0);
    chk("act_trfc", v_cyc - ref_v, 32);

    send(ACT, 1'b0, 3'd4, 7'd20, 3'd0, 1'b0);
    send(REF, 1'b0, 3'd0, 7'd0, 3'd0, 1'b0);
    chk("refx_err", err_cnt, 1);
    chk("refx_nostrobe", valid_cnt, 0);
    chk("refx_open", bank_open, 8'h11);

    send(PRE, 1'b0, 3'd6, 7'd0, 3'd0, 1'b0);
    chk("noop_err", err_cnt, 0);
    chk("noop_nostrobe", valid_cnt, 0);
    chk("noop_ack_lat", ack_cyc - req_cyc, 1);

    // COL waits on tRCD when reset hits it
    send(ACT, 1'b0, 3'd5, 7'd9, 3'd0, 1'b0);
    @(negedge clk);
    cmd_req = 1'b1; cmd = COL; bank_id = 3'd5; col_id = 3'd1; we = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; cmd_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", dram_cmd_valid, 0);
    chk("mid_rst_ack", cmd_ack, 0);
    chk("mid_rst_cmd", dram_cmd, 0);
    chk("mid_rst_bank", dram_bank, 0);
    chk("mid_rst_open", bank_open, 0);
    rst = 1'b0;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (dram_cmd_valid || cmd_ack || cmd_err) quiet++;
    end
    chk("abort_quiet", quiet, 0);

    send(ACT, 1'b0, 3'd1, 7'd100, 3'd0, 1'b0);
    chk("post_rst_latency", v_cyc - req_cyc, 1);
    chk("post_rst_row", v_row, 100);
    chk("post_rst_open", v_open, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dram_cmd_timer.md
# dram_cmd_timer

Downstream stage of `dram_ctrl_fsm`: accepts its `cmd_req`/`cmd` requests over a four-phase req/ack handshake and returns `cmd_ack`. Before driving each DRAM command onto the device command bus, it enforces per-bank DRAM timing (tRCD, tRAS, tRP) and refresh recovery (tRFC). It also tracks open banks and open rows, and flags illegal command sequences.

## Interface
- `NUMBER_OF_BANKS`, 8, bank count
- `NUMBER_OF_ROWS`, 128, rows per bank
- `NUMBER_OF_COLS`, 8, columns per row
- `T_RCD`, 6, min cycles ACT→COL, same bank
- `T_RAS`, 16, min cycles ACT→PRE, same bank
- `T_RP`, 6, min cycles PRE→ACT (same bank), PRE→REF (any bank)
- `T_RFC`, 32, min cycles REF→any command
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `cmd_req`  in  1  request level from controller FSM
- `cmd`  in  2  00 REF, 01 ACT, 10 COL, 11 PRE
- `we`  in  1  COL direction: 1 write, 0 read
- `bank_id`  in  clog2(NUMBER_OF_BANKS)  target bank
- `row_id`  in  clog2(NUMBER_OF_ROWS)  row, used by ACT
- `col_id`  in  clog2(NUMBER_OF_COLS)  column, used by COL
- `cmd_ack`  out  1  handshake acknowledge
- `cmd_err`  out  1  one-cycle pulse: illegal command dropped
- `dram_cmd_valid`  out  1  one-cycle command strobe to device
- `dram_cmd`  out  2  issued command, same encoding as `cmd`
- `dram_we`, `dram_bank`, `dram_row`, `dram_col`  out  1 / bank / row / col widths  issued fields
- `bank_open`  out  NUMBER_OF_BANKS  bit b = bank b has an open row

## Operation
- States:
  - IDLE → WAIT on sampled `cmd_req`=1. `cmd`, `we` and the ids are latched on that edge; later input changes are ignored.
  - WAIT → ISSUE once the timing rule for the latched command is met. WAIT → ACK with `cmd_err` pulse if the command is illegal.
  - ISSUE: registered `dram_cmd_valid`=1 and dram_* fields driven for exactly one cycle. Next state is ACK.
  - ACK: `cmd_ack`=1. Stays until `cmd_req`=0 is sampled, then → IDLE with `cmd_ack`=0.
- Legality checks in WAIT:
  - COL to a closed bank: illegal.
  - ACT to an open bank: illegal.
  - REF while any `bank_open` bit is set: illegal.
  - PRE to a closed bank: legal no-op. Goes directly to ACK with no `dram_cmd_valid` and no error.
- Per-bank counters:
  - `cnt_act[b]` counts cycles since that bank's last ACT valid cycle; `cnt_pre[b]` counts cycles since its last PRE.
  - Global `cnt_ref` counts cycles since the last REF.
  - Each counter is cleared in the issuing cycle and saturates at max(`T_RAS`, `T_RFC`).
  - Widths are clog2 of that maximum plus 1.
- Timing rules, measured as the distance between `dram_cmd_valid` cycles:
  - COL ≥ `T_RCD` after ACT (same bank).
  - PRE ≥ `T_RAS` after ACT (same bank).
  - ACT ≥ `T_RP` after PRE (same bank).
  - REF ≥ `T_RP` after every bank's last PRE.
  - Any command ≥ `T_RFC` after REF.
- If a legal command has been waiting, it issues exactly at the minimum distance, not later.
- Open-bank tracking:
  - ACT sets `bank_open[b]` and stores the row in an open-row register.
  - PRE clears `bank_open[b]`.
  - REF leaves all banks closed.
- COL does not change open state.

## Timing
- Reset (sync, next edge):
  - State → IDLE.
  - `cmd_ack`, `cmd_err`, `dram_cmd_valid` = 0.
  - `dram_cmd`, `dram_we`, `dram_bank`, `dram_row`, `dram_col` = 0.
  - `bank_open` = 0.
  - All counters saturated, so the first commands carry no timing wait.
- Reset mid-operation aborts any latched command: no strobe and no ack afterwards.
- Minimum latency:
  - `cmd_req` sampled at edge k → `dram_cmd_valid` high after edge k+1 → `cmd_ack` high after edge k+2.
  - `cmd_err` pulses in the cycle after edge k+1; `cmd_ack` rises on that same edge.
- `cmd_ack` falls on the edge after `cmd_req`=0 is sampled in ACK; minimum width 1 cycle.
- `cmd_req` dropping before ack (protocol violation): the latched command still completes, and ack pulses for one cycle.
- Counters increment every cycle, including while in IDLE.

## Test plan
- ACT bank 3 row 42 from reset → `dram_cmd_valid` 1 cycle after request is sampled, `dram_cmd`=01, `dram_bank`=3, `dram_row`=42, `bank_open`=8'b0000_1000. Then `cmd_ack` high until `cmd_req` low, then low one cycle later.
- ACT bank 3, then immediate COL (`we`=1, col 5) bank 3 → COL strobe exactly 6 cycles after ACT strobe, `dram_we`=1, `dram_col`=5. A following PRE bank 3 strobes exactly 16 cycles after the ACT strobe and clears `bank_open[3]`.
- COL bank 1 (closed) → `cmd_err` 1 cycle, no `dram_cmd_valid`, normal ack. ACT to already-open bank 3 → `cmd_err`.
- Banks 0 and 2 open; PRE 0, PRE 2, then REF → REF strobe exactly 6 cycles after PRE 2 strobe. An ACT bank 0 right after → strobe exactly 32 cycles after REF.
- REF with bank 4 open → `cmd_err`, `bank_open` unchanged.
- `rst` asserted while in WAIT for a COL → next cycle all outputs 0, `bank_open`=0. A new ACT then issues with minimum latency.
